// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and the
// byte-lane width used by the lane extract/merge logic.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (word access with an odd
// byte address is trapped with rsp_err instead of being forced aligned).

// `define LSU_MISALIGN_TRAP_EN

package load_store_unit_pkg;

    // Width of one byte lane inside a data word
    localparam int BYTE_W = 8;

    // Access sequencing states
    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_RD     = 3'd1,
        LSU_RMW_RD = 3'd2,
        LSU_WR     = 3'd3,
        LSU_RESP   = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the request, response and data-memory signals around the
// load/store unit. The slave modport is the unit itself; the master modport
// is its environment (MEM pipeline stage, response consumer and data_memory).

interface load_store_unit_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_signed;
    logic [MEM_AW:0]   req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_read;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: pulls one byte out of a word (placed in the low lane and
// sign- or zero-extended) and merges a new byte into a word for
// read-modify-write byte stores. Purely combinational.

module lsu_byte_lane
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic              lane_i,
    input  logic              sign_ext_i,
    input  logic [BYTE_W-1:0] new_byte_i,
    output logic [DATA_W-1:0] extract_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [BYTE_W-1:0] laneByte;

    // Select the addressed byte; lane 1 is the high byte of the word
    always_comb begin
        laneByte = word_i[BYTE_W-1:0];
        if (lane_i) begin
            laneByte = word_i[2*BYTE_W-1:BYTE_W];
        end
    end

    assign extract_o = {{(DATA_W-BYTE_W){sign_ext_i & laneByte[BYTE_W-1]}}, laneByte};

    // Replace only the addressed lane, keeping the other lane from memory
    always_comb begin
        merge_o = word_i;
        if (lane_i) begin
            merge_o[2*BYTE_W-1:BYTE_W] = new_byte_i;
        end else begin
            merge_o[BYTE_W-1:0] = new_byte_i;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port. Sequences word
// loads, word stores and read-modify-write byte stores toward data_memory
// (which has no byte enables) and returns one response per request.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, a word access
// with req_addr[0]=1 goes straight to a response with rsp_err=1 and leaves
// memory untouched; otherwise the odd address bit is ignored for word
// accesses and rsp_err is always 0.

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 9
) (
    input  logic clk,
    input  logic rst,
    load_store_unit_if.slave bus
);

    lsu_state_e        state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              byte_q;
    logic              signed_q;
    logic              lane_q;
    logic [BYTE_W-1:0] wbyte_q;

    logic [DATA_W-1:0] laneExt;
    logic [DATA_W-1:0] laneMerged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;
    logic misalignedReq;

    assign misalignedReq = !bus.req_byte && bus.req_addr[0];
`endif

    lsu_byte_lane #(
        .DATA_W (DATA_W)
    ) u_byte_lane (
        .word_i     (bus.mem_rdata),
        .lane_i     (lane_q),
        .sign_ext_i (signed_q),
        .new_byte_i (wbyte_q),
        .extract_o  (laneExt),
        .merge_o    (laneMerged)
    );

    // Access sequencer with all memory and response outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            byte_q      <= 1'b0;
            signed_q    <= 1'b0;
            lane_q      <= 1'b0;
            wbyte_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        byte_q      <= bus.req_byte;
                        signed_q    <= bus.req_signed;
                        lane_q      <= bus.req_addr[0];
                        wbyte_q     <= bus.req_wdata[BYTE_W-1:0];
                        mem_addr_q  <= bus.req_addr[MEM_AW:1];
                        req_ready_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalignedReq) begin
                            state_q     <= LSU_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else
`endif
                        if (bus.req_we && !bus.req_byte) begin
                            state_q     <= LSU_WR;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else if (bus.req_we) begin
                            state_q     <= LSU_RMW_RD;
                            mem_read_q  <= 1'b1;
                        end else begin
                            state_q     <= LSU_RD;
                            mem_read_q  <= 1'b1;
                        end
                    end
                end
                LSU_RD: begin
                    rsp_rdata_q <= byte_q ? laneExt : bus.mem_rdata;
                    mem_read_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= LSU_RESP;
                end
                LSU_RMW_RD: begin
                    mem_wdata_q <= laneMerged;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    state_q     <= LSU_WR;
                end
                LSU_WR: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= LSU_IDLE;
                    end
                end
                default: begin
                    state_q     <= LSU_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit paired with a behavioural data_memory.
// Directed steps push expected responses to a scoreboard queue; responses
// are popped and compared when rsp_valid appears.

module tb_load_store_unit;

    localparam int DATA_W = 16;
    localparam int MEM_AW = 9;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int vectors = 0;
    int miscompares = 0;

    exp_t expQ[$];

    int readCount = 0;
    int writeCount = 0;
    int overlapCount = 0;
    int cycleNow = 0;
    int firstReadCycle = 0;
    int firstWriteCycle = 0;
    logic [MEM_AW-1:0] lastReadAddr = '0;
    logic [MEM_AW-1:0] lastWriteAddr = '0;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    load_store_unit_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();

    load_store_unit #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural data_memory: combinational read, write commits at the edge
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Bus activity monitor counting memory cycles seen at each edge
    always @(posedge clk) begin
        cycleNow = cycleNow + 1;
        if (!rst) begin
            if (bus.mem_read) begin
                if (readCount == 0) firstReadCycle = cycleNow;
                readCount = readCount + 1;
                lastReadAddr = bus.mem_addr;
            end
            if (bus.mem_write) begin
                if (writeCount == 0) firstWriteCycle = cycleNow;
                writeCount = writeCount + 1;
                lastWriteAddr = bus.mem_addr;
            end
            if (bus.mem_read && bus.mem_write) begin
                overlapCount = overlapCount + 1;
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetCounters();
        readCount = 0;
        writeCount = 0;
        firstReadCycle = 0;
        firstWriteCycle = 0;
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic byteAcc,
                                 input logic sgn, input logic [MEM_AW:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic pushExp,
                                 input logic [DATA_W-1:0] expRdata, input logic expErr);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkVal({tag, "_ready"}, bus.req_ready, 1);
        bus.req_we     = we;
        bus.req_byte   = byteAcc;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (pushExp) expQ.push_back('{rdata: expRdata, err: expErr});
    endtask

    task automatic waitResp(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.rsp_valid && cyc < 20);
        checkVal({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        e = '{rdata: '0, err: 1'b0};
        checkVal({tag, "_sb_nonempty"}, (expQ.size() != 0), 1);
        if (expQ.size() != 0) e = expQ.pop_front();
        checkVal({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        checkVal({tag, "_err"}, bus.rsp_err, e.err);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic doTxn(input string tag, input logic we, input logic byteAcc, input logic sgn,
                         input logic [MEM_AW:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] expRdata, input logic expErr, input int expLat);
        int lat;
        applyStimulus(tag, we, byteAcc, sgn, addr, wdata, 1'b1, expRdata, expErr);
        waitResp(tag, lat);
        checkVal({tag, "_latency"}, lat, expLat);
        checkOutput(tag);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int lat;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        #2;
        checkVal("rst_req_ready", bus.req_ready, 1);
        checkVal("rst_rsp_valid", bus.rsp_valid, 0);
        checkVal("rst_rsp_rdata", bus.rsp_rdata, 0);
        checkVal("rst_rsp_err", bus.rsp_err, 0);
        checkVal("rst_mem_read", bus.mem_read, 0);
        checkVal("rst_mem_write", bus.mem_write, 0);
        checkVal("rst_mem_addr", bus.mem_addr, 0);
        checkVal("rst_mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        resetCounters();
        doTxn("wst_abcd", 1, 0, 0, 10'h004, 16'hABCD, 16'h0000, 0, 2);
        checkVal("wst_write_cycles", writeCount, 1);
        checkVal("wst_write_addr", lastWriteAddr, 9'h002);
        checkVal("wst_read_cycles", readCount, 0);
        doTxn("wld_abcd", 0, 0, 0, 10'h004, 16'h0000, 16'hABCD, 0, 2);

        // Byte read-modify-write
        doTxn("wst_1234", 1, 0, 0, 10'h008, 16'h1234, 16'h0000, 0, 2);
        resetCounters();
        doTxn("bst_ef", 1, 1, 0, 10'h009, 16'h77EF, 16'h0000, 0, 3);
        checkVal("bst_read_cycles", readCount, 1);
        checkVal("bst_write_cycles", writeCount, 1);
        checkVal("bst_read_then_write", firstWriteCycle - firstReadCycle, 1);
        checkVal("bst_write_addr", lastWriteAddr, 9'h004);
        doTxn("wld_ef34", 0, 0, 0, 10'h008, 16'h0000, 16'hEF34, 0, 2);

        // Byte loads with sign and zero extension
        doTxn("wst_80ff", 1, 0, 0, 10'h010, 16'h80FF, 16'h0000, 0, 2);
        doTxn("bld_hi_s", 0, 1, 1, 10'h011, 16'h0000, 16'hFF80, 0, 2);
        doTxn("bld_hi_u", 0, 1, 0, 10'h011, 16'h0000, 16'h0080, 0, 2);
        doTxn("bld_lo_s", 0, 1, 1, 10'h010, 16'h0000, 16'hFFFF, 0, 2);
        doTxn("bld_lo_u", 0, 1, 0, 10'h010, 16'h0000, 16'h00FF, 0, 2);

        // Response backpressure with a second request waiting
        doTxn("wst_5678", 1, 0, 0, 10'h020, 16'h5678, 16'h0000, 0, 2);
        applyStimulus("bp_load", 0, 0, 0, 10'h020, 16'h0000, 1, 16'h5678, 0);
        waitResp("bp_load", lat);
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 10'h004;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("bp_rsp_valid", bus.rsp_valid, 1);
            checkVal("bp_rsp_rdata", bus.rsp_rdata, 16'h5678);
            checkVal("bp_req_ready", bus.req_ready, 0);
            checkVal("bp_no_accept", bus.mem_read, 0);
        end
        checkOutput("bp_load");
        checkVal("bp_handshake_idle", bus.req_ready, 1);
        checkVal("bp_handshake_no_accept", bus.mem_read, 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        expQ.push_back('{rdata: 16'hABCD, err: 1'b0});
        checkVal("bp_second_accepted", bus.mem_read, 1);
        waitResp("bp_second", lat);
        checkVal("bp_second_latency", lat, 2);
        checkOutput("bp_second");

        // Reset while in the read half of a byte store
        applyStimulus("rst_rmw", 1, 1, 0, 10'h009, 16'h0055, 0, 16'h0000, 0);
        checkVal("rst_rmw_in_read", bus.mem_read, 1);
        rst = 1'b1;
        #1;
        checkVal("rst_rmw_mem_read", bus.mem_read, 0);
        checkVal("rst_rmw_mem_write", bus.mem_write, 0);
        checkVal("rst_rmw_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("rst_rmw_req_ready", bus.req_ready, 1);
        repeat (3) @(negedge clk);
        checkVal("rst_rmw_no_rsp", bus.rsp_valid, 0);
        doTxn("rst_rmw_recheck", 0, 0, 0, 10'h008, 16'h0000, 16'hEF34, 0, 2);

        // Misaligned word accesses
        doTxn("wst_2468", 1, 0, 0, 10'h002, 16'h2468, 16'h0000, 0, 2);
        resetCounters();
`ifdef LSU_MISALIGN_TRAP_EN
        doTxn("mis_load", 0, 0, 0, 10'h003, 16'h0000, 16'h0000, 1, 1);
        checkVal("mis_load_reads", readCount, 0);
        resetCounters();
        doTxn("mis_store", 1, 0, 0, 10'h005, 16'h1111, 16'h0000, 1, 1);
        checkVal("mis_store_writes", writeCount, 0);
        doTxn("mis_store_untouched", 0, 0, 0, 10'h004, 16'h0000, 16'hABCD, 0, 2);
`else
        doTxn("mis_load", 0, 0, 0, 10'h003, 16'h0000, 16'h2468, 0, 2);
        checkVal("mis_load_reads", readCount, 1);
        checkVal("mis_load_addr", lastReadAddr, 9'h001);
        resetCounters();
        doTxn("mis_store", 1, 0, 0, 10'h005, 16'h1111, 16'h0000, 0, 2);
        checkVal("mis_store_writes", writeCount, 1);
        checkVal("mis_store_addr", lastWriteAddr, 9'h002);
        doTxn("mis_store_readback", 0, 0, 0, 10'h004, 16'h0000, 16'h1111, 0, 2);
`endif

        checkVal("never_read_and_write", overlapCount, 0);
        checkVal("scoreboard_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
